// File: rtl/text_write_ctrl_pkg.sv
// Shared constants and types for the text tile RAM write sequencer.
package text_write_ctrl_pkg;

  localparam int unsigned DefCols = 40;
  localparam int unsigned DefRows = 60;

  localparam logic [7:0] ChSpace = 8'h20;
  localparam logic [7:0] ChBs    = 8'h08;
  localparam logic [7:0] ChLf    = 8'h0A;
  localparam logic [7:0] ChFf    = 8'h0C;
  localparam logic [7:0] ChCr    = 8'h0D;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StClear
  } state_e;

  typedef enum logic [2:0] {
    CurNone,
    CurIncX,
    CurDecX,
    CurIncY,
    CurHomeX,
    CurNewline,
    CurHome
  } cur_cmd_e;

  function automatic logic is_printable(logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_cursor_unit.sv
// Cursor x/y registers with the screen wrap rules; one command per cycle.
module text_cursor_unit
  import text_write_ctrl_pkg::*;
#(
  parameter int unsigned COLS = DefCols,
  parameter int unsigned ROWS = DefRows,
  parameter int unsigned X_W  = 6,
  parameter int unsigned Y_W  = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  cur_cmd_e       cmd,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [Y_W-1:0] y_inc;
  logic           x_last;

  always_comb begin
    x_last = (x_q == X_W'(COLS - 1));
    y_inc  = (y_q == Y_W'(ROWS - 1)) ? '0 : y_q + 1'b1;
    x_d    = x_q;
    y_d    = y_q;
    unique case (cmd)
      CurIncX: begin
        if (x_last) begin
          x_d = '0;
          y_d = y_inc;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      CurDecX: begin
        if (x_q != '0) x_d = x_q - 1'b1;
      end
      CurIncY:  y_d = y_inc;
      CurHomeX: x_d = '0;
      CurNewline: begin
        x_d = '0;
        y_d = y_inc;
      end
      CurHome: begin
        x_d = '0;
        y_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/text_write_ctrl.sv
// Write-port sequencer for the text tile RAM: UART bytes, control chars, buttons, clear sweeps.
module text_write_ctrl
  import text_write_ctrl_pkg::*;
#(
  parameter int unsigned COLS = DefCols,
  parameter int unsigned ROWS = DefRows,
  parameter int unsigned X_W  = 6,
  parameter int unsigned Y_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_empty,
  input  logic [7:0]         rx_data,
  output logic               rd_uart,
  input  logic               btn_right,
  input  logic               btn_down,
  input  logic               btn_clear,
  output logic               we,
  output logic [Y_W+X_W-1:0] waddr,
  output logic [6:0]         wdata,
  output logic [X_W-1:0]     x_cursor,
  output logic [Y_W-1:0]     y_cursor,
  output logic               busy
);

  state_e         state_q, state_d;
  logic [7:0]     byte_q, byte_d;
  logic           p_right_q, p_right_d;
  logic           p_down_q, p_down_d;
  logic           p_clear_q, p_clear_d;
  logic [X_W-1:0] clr_x_q, clr_x_d;
  logic [Y_W-1:0] clr_y_q, clr_y_d;
  logic [X_W-1:0] x_prev;
  cur_cmd_e       cur_cmd;

  text_cursor_unit #(
    .COLS (COLS),
    .ROWS (ROWS),
    .X_W  (X_W),
    .Y_W  (Y_W)
  ) u_cursor (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cur_cmd),
    .x     (x_cursor),
    .y     (y_cursor)
  );

  // A tick arriving in the same cycle is serviced as if already pending.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    p_right_d = p_right_q | btn_right;
    p_down_d  = p_down_q | btn_down;
    p_clear_d = p_clear_q | btn_clear;
    clr_x_d   = clr_x_q;
    clr_y_d   = clr_y_q;
    cur_cmd   = CurNone;
    rd_uart   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (p_clear_q || btn_clear) begin
          state_d   = StClear;
          p_clear_d = 1'b0;
        end else if (!rx_empty && rst_n) begin
          rd_uart = 1'b1;
          byte_d  = rx_data;
          state_d = StExec;
        end else if (p_right_q || btn_right) begin
          cur_cmd   = CurIncX;
          p_right_d = 1'b0;
        end else if (p_down_q || btn_down) begin
          cur_cmd  = CurIncY;
          p_down_d = 1'b0;
        end
      end
      StExec: begin
        state_d = StIdle;
        if (is_printable(byte_q)) begin
          cur_cmd = CurIncX;
        end else begin
          unique case (byte_q)
            ChCr: cur_cmd = CurHomeX;
            ChLf: cur_cmd = CurNewline;
            ChBs: if (x_cursor != '0) cur_cmd = CurDecX;
            ChFf: state_d = StClear;
            default: ;
          endcase
        end
      end
      StClear: begin
        if (clr_x_q == X_W'(COLS - 1)) begin
          clr_x_d = '0;
          if (clr_y_q == Y_W'(ROWS - 1)) begin
            clr_y_d = '0;
            cur_cmd = CurHome;
            state_d = StIdle;
          end else begin
            clr_y_d = clr_y_q + 1'b1;
          end
        end else begin
          clr_x_d = clr_x_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write port decodes from registered state only.
  always_comb begin
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    x_prev = x_cursor - 1'b1;
    unique case (state_q)
      StExec: begin
        if (is_printable(byte_q)) begin
          we    = 1'b1;
          waddr = {y_cursor, x_cursor};
          wdata = byte_q[6:0];
        end else if (byte_q == ChBs && x_cursor != '0) begin
          we    = 1'b1;
          waddr = {y_cursor, x_prev};
          wdata = ChSpace[6:0];
        end
      end
      StClear: begin
        we    = 1'b1;
        waddr = {clr_y_q, clr_x_q};
        wdata = ChSpace[6:0];
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      byte_q    <= '0;
      p_right_q <= 1'b0;
      p_down_q  <= 1'b0;
      p_clear_q <= 1'b0;
      clr_x_q   <= '0;
      clr_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      p_right_q <= p_right_d;
      p_down_q  <= p_down_d;
      p_clear_q <= p_clear_d;
      clr_x_q   <= clr_x_d;
      clr_y_q   <= clr_y_d;
    end
  end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed bench for text_write_ctrl: byte writes, control chars, buttons, clear sweeps, reset.
module tb_text_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rd_uart;
  logic        btn_right = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_clear = 1'b0;
  logic        we;
  logic [11:0] waddr;
  logic [6:0]  wdata;
  logic [5:0]  x_cursor;
  logic [5:0]  y_cursor;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt = 0;
  int rd_cnt = 0;
  int bad_data = 0;
  logic [11:0] last_addr = '0;

  text_write_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_empty  (rx_empty),
    .rx_data   (rx_data),
    .rd_uart   (rd_uart),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_clear (btn_clear),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .x_cursor  (x_cursor),
    .y_cursor  (y_cursor),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Write/pop monitor, sampled mid low phase.
  always @(negedge clk) begin
    #2;
    if (we) begin
      we_cnt++;
      last_addr = waddr;
      if (wdata != 7'h20) bad_data++;
    end
    if (rd_uart) rd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_empty = 1'b1;
    btn_right = 1'b0;
    btn_down = 1'b0;
    btn_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // kind: 0 right, 1 down
  task automatic press(input int kind, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (kind == 0) btn_right = 1'b1;
      else btn_down = 1'b1;
      @(negedge clk);
      btn_right = 1'b0;
      btn_down = 1'b0;
    end
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic exp_we, input logic [11:0] exp_addr,
                           input logic [6:0] exp_data);
    @(negedge clk);
    rx_data = b;
    rx_empty = 1'b0;
    #1;
    check("rd_uart_pulse", rd_uart, 1);
    @(negedge clk);
    rx_empty = 1'b1;
    #1;
    check("rd_uart_single", rd_uart, 0);
    check("exec_busy", busy, 1);
    check("exec_we", we, exp_we);
    if (exp_we) begin
      check("exec_waddr", waddr, exp_addr);
      check("exec_wdata", wdata, exp_data);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    // Reset state, with a byte waiting that must not be popped.
    rx_empty = 1'b0;
    rx_data = 8'h41;
    #1;
    check("rst_rd_uart", rd_uart, 0);
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_x", x_cursor, 0);
    check("rst_y", y_cursor, 0);
    check("rst_busy", busy, 0);
    do_reset();

    // Printable at origin
    push_byte(8'h41, 1'b1, 12'h000, 7'h41);
    check("a_x", x_cursor, 1);
    check("a_y", y_cursor, 0);
    check("a_idle_we", we, 0);

    // Printable at end of row wraps to next row
    do_reset();
    press(1, 5);
    press(0, 39);
    check("pos_x39", x_cursor, 39);
    check("pos_y5", y_cursor, 5);
    push_byte(8'h5A, 1'b1, 12'h167, 7'h5A);
    check("z_x", x_cursor, 0);
    check("z_y", y_cursor, 6);

    // LF on last row, BS, CR, dropped byte, button wraps
    do_reset();
    press(1, 59);
    check("pos_y59", y_cursor, 59);
    push_byte(8'h0A, 1'b0, 12'h000, 7'h00);
    check("lf_x", x_cursor, 0);
    check("lf_y", y_cursor, 0);
    push_byte(8'h08, 1'b0, 12'h000, 7'h00);
    check("bs0_x", x_cursor, 0);
    press(0, 3);
    push_byte(8'h08, 1'b1, 12'h002, 7'h20);
    check("bs3_x", x_cursor, 2);
    push_byte(8'h51, 1'b1, 12'h002, 7'h51);
    check("q_x", x_cursor, 3);
    push_byte(8'h0D, 1'b0, 12'h000, 7'h00);
    check("cr_x", x_cursor, 0);
    check("cr_y", y_cursor, 0);
    push_byte(8'h01, 1'b0, 12'h000, 7'h00);
    check("drop_x", x_cursor, 0);
    press(0, 40);
    check("rwrap_x", x_cursor, 0);
    check("rwrap_y", y_cursor, 1);
    press(1, 59);
    check("dwrap_y", y_cursor, 0);

    // Form feed sweep
    do_reset();
    press(0, 3);
    we_cnt = 0;
    bad_data = 0;
    push_byte(8'h0C, 1'b0, 12'h000, 7'h00);
    check("ff_busy", busy, 1);
    wait_idle(3000);
    check("ff_we_count", we_cnt, 2400);
    check("ff_bad_wdata", bad_data, 0);
    check("ff_last_addr", last_addr, 12'hEE7);
    check("ff_x", x_cursor, 0);
    check("ff_y", y_cursor, 0);
    check("ff_idle_we", we, 0);

    // Clear, byte and right tick together; extra right ticks during clear merge
    do_reset();
    @(negedge clk);
    we_cnt = 0;
    rd_cnt = 0;
    bad_data = 0;
    btn_clear = 1'b1;
    btn_right = 1'b1;
    rx_data = 8'h42;
    rx_empty = 1'b0;
    #1;
    check("sim_no_rd", rd_uart, 0);
    @(negedge clk);
    btn_clear = 1'b0;
    btn_right = 1'b0;
    repeat (10) @(negedge clk);
    btn_right = 1'b1;
    @(negedge clk);
    btn_right = 1'b0;
    @(negedge clk);
    btn_right = 1'b1;
    @(negedge clk);
    btn_right = 1'b0;
    #1;
    wait_idle(3000);
    check("sim_rd_during_clear", rd_cnt, 0);
    check("sim_we_count", we_cnt, 2400);
    check("sim_bad_wdata", bad_data, 0);
    check("sim_rd_after", rd_uart, 1);
    check("sim_home_x", x_cursor, 0);
    @(negedge clk);
    rx_empty = 1'b1;
    #1;
    check("sim_we", we, 1);
    check("sim_waddr", waddr, 12'h000);
    check("sim_wdata", wdata, 7'h42);
    @(negedge clk);
    #1;
    check("sim_x_after_byte", x_cursor, 1);
    @(negedge clk);
    #1;
    check("sim_x_after_right", x_cursor, 2);
    @(negedge clk);
    #1;
    check("sim_x_merged", x_cursor, 2);

    // Reset in the middle of a sweep
    do_reset();
    @(negedge clk);
    btn_clear = 1'b1;
    rx_data = 8'h43;
    rx_empty = 1'b0;
    @(negedge clk);
    btn_clear = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", we, 0);
    check("mid_rst_waddr", waddr, 0);
    check("mid_rst_wdata", wdata, 0);
    check("mid_rst_rd", rd_uart, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_x", x_cursor, 0);
    check("mid_rst_y", y_cursor, 0);
    we_cnt = 0;
    repeat (3) @(negedge clk);
    #1;
    check("mid_rst_no_writes", we_cnt, 0);
    rst_n = 1'b1;
    #1;
    check("rel_rd", rd_uart, 1);
    @(negedge clk);
    rx_empty = 1'b1;
    #1;
    check("rel_we", we, 1);
    check("rel_waddr", waddr, 12'h000);
    check("rel_wdata", wdata, 7'h43);
    @(negedge clk);
    #1;
    check("rel_x", x_cursor, 1);
    check("rel_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
